// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared types and constants for the truth-table probe
// Purpose: FSM state encoding and sizing constants used by the probe and its settle timer.
// Ports: none (package).
package truth_table_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } probe_state_t;

   localparam int NUM_INPUTS = 3;
   localparam int NUM_COMBOS = 8;
   localparam int TABLE_W    = 8;
   localparam int SETTLE_W   = $clog2(16);

endpackage

// File: rtl/probe_settle_timer.sv
// rtl/probe_settle_timer.sv - loadable down-counter timing how long a combination settles
// Purpose: counts down from a loaded value once per cycle; expired while the count is zero.
// Ports: clk, rst_n (sync, active-low), clear (force count to 0), load/load_value
//        (preset the count, wins over clear), expired (count == 0).
module probe_settle_timer
   import truth_table_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                load,
   input  logic [SETTLE_W-1:0] load_value,
   output logic                expired
);

   logic [SETTLE_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (clear) begin
         count <= '0;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/truth_table_probe.sv
// rtl/truth_table_probe.sv - sweeps a 3-input gate and captures its truth-table code
// Purpose: drives idx 0..7 onto the gate under test, samples its output after a
//          settle interval and publishes the 8-bit code (idx 0 at the MSB).
// Ports: clk, rst_n (sync, active-low), start (sweep request), sample (gate output),
//        drive_in (gate inputs {in1,in2,in3}), busy, done (1-cycle pulse),
//        table_out (captured code), match (table_out == EXPECTED).
module truth_table_probe
   import truth_table_pkg::*;
#(
   parameter int               SETTLE_CYCLES = 2,
   parameter logic [TABLE_W-1:0] EXPECTED    = 8'h74
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sample,
   output logic [NUM_INPUTS-1:0] drive_in,
   output logic                  busy,
   output logic                  done,
   output logic [TABLE_W-1:0]    table_out,
   output logic                  match
);

   localparam logic [NUM_INPUTS-1:0] LAST_IDX = NUM_INPUTS'(NUM_COMBOS - 1);

   probe_state_t          state, next_state;
   logic [NUM_INPUTS-1:0] idx, idx_next;
   logic [TABLE_W-1:0]    cap, cap_next;
   logic                  publish;
   logic                  timer_clear, timer_load, timer_expired;
   logic                  sweeping_next;

   probe_settle_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (timer_clear),
      .load       (timer_load),
      .load_value (SETTLE_W'(SETTLE_CYCLES)),
      .expired    (timer_expired)
   );

   always_comb begin
      next_state  = state;
      idx_next    = idx;
      cap_next    = cap;
      publish     = 1'b0;
      timer_clear = 1'b0;
      timer_load  = 1'b0;
      case (state)
         // FINISH is the done cycle; it behaves as idle so a start there
         // launches the next sweep without a gap.
         IDLE, FINISH: begin
            next_state  = IDLE;
            timer_clear = 1'b1;
            if (start) begin
               next_state = DRIVE;
               idx_next   = '0;
               timer_load = 1'b1;
            end
         end
         DRIVE: begin
            if (timer_expired) begin
               next_state = SAMPLE;
            end
         end
         SAMPLE: begin
            cap_next[LAST_IDX - idx] = sample;
            if (idx == LAST_IDX) begin
               next_state = FINISH;
               publish    = 1'b1;
            end else begin
               next_state = DRIVE;
               idx_next   = idx + 1'b1;
               timer_load = 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign sweeping_next = (next_state == DRIVE) || (next_state == SAMPLE);

   // Outputs are registered from the next-state values so they line up with
   // the state they describe while keeping sample/start off any output path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         cap       <= '0;
         drive_in  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         table_out <= '0;
         match     <= 1'b0;
      end else begin
         state    <= next_state;
         idx      <= idx_next;
         cap      <= cap_next;
         drive_in <= sweeping_next ? idx_next : '0;
         busy     <= sweeping_next;
         done     <= (next_state == FINISH);
         if (publish) begin
            table_out <= cap_next;
            match     <= (cap_next == EXPECTED);
         end
      end
   end

endmodule
